// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU data-memory interface. Word reads and
//   byte-lane-masked writes complete LATENCY cycles after acceptance, marked
//   by a one-cycle data_ready pulse. LATENCY=1 behaves as a one-cycle
//   synchronous SRAM and sustains one access per cycle.
//
// Parameters:
//   DEPTH    number of 32-bit words (power of 2)
//   LATENCY  cycles from acceptance to response, 1..8
//
// Ports:
//   clk         clock, posedge
//   rst         asynchronous active-low reset
//   data_addr   byte address; word index = data_addr[AW+1:2]
//   data_read   read request
//   data_write  byte-lane write enables (nonzero = write request)
//   data_in     write data
//   data_out    registered read data (read-before-write on read+write)
//   data_ready  one-cycle completion pulse
//   access_err  out-of-range flag, valid with data_ready
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//   Defined:   addresses with nonzero bits above the array are rejected
//              (no write, read data 0, access_err=1).
//   Undefined: upper address bits are dropped (index wraps), access_err=0.

module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic        data_read,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        access_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          accept, do_access;

    logic [31:0]   mem [DEPTH];

    // In-flight request, captured at acceptance
    logic [AW-1:0] lat_idx;
    logic [3:0]    lat_we;
    logic [31:0]   lat_din;
    logic          lat_rd;
    logic          lat_oob;

    // Effective access fields: straight from the ports when the access
    // happens on the accepting edge (IDLE), otherwise the latched copy.
    logic [AW-1:0] acc_idx;
    logic [3:0]    acc_we;
    logic [31:0]   acc_din;
    logic          acc_rd;
    logic          acc_oob;

    logic          req;
    logic          in_oob;
    logic          unused_addr;

    assign req         = data_read | (|data_write);
    // Bits [1:0] and (without bounds checking) the upper bits are dropped.
    assign unused_addr = ^data_addr;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign in_oob = (data_addr >> (AW + 2)) != 32'd0;
`else
    assign in_oob = 1'b0;
`endif

    assign acc_idx = (state == IDLE) ? data_addr[AW+1:2] : lat_idx;
    assign acc_we  = (state == IDLE) ? data_write        : lat_we;
    assign acc_din = (state == IDLE) ? data_in           : lat_din;
    assign acc_rd  = (state == IDLE) ? data_read         : lat_rd;
    assign acc_oob = (state == IDLE) ? in_oob            : lat_oob;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY > 1) begin
                        state_n = BUSY;
                        cnt_n   = 4'(LATENCY - 1);
                    end else begin
                        do_access = 1'b1;
                    end
                end
            end
            BUSY: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    do_access = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_idx    <= '0;
            lat_we     <= 4'd0;
            lat_din    <= 32'd0;
            lat_rd     <= 1'b0;
            lat_oob    <= 1'b0;
            data_out   <= 32'd0;
            data_ready <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            if (accept) begin
                lat_idx <= data_addr[AW+1:2];
                lat_we  <= data_write;
                lat_din <= data_in;
                lat_rd  <= data_read;
                lat_oob <= in_oob;
            end
            data_ready <= do_access;
            err_q      <= do_access & acc_oob;
            // Non-blocking read of mem yields the pre-write word.
            if (do_access && acc_rd)
                data_out <= acc_oob ? 32'd0 : mem[acc_idx];
        end
    end

    // Array is never reset. The rst gate keeps an IDLE-state request from
    // writing while reset is held.
    always_ff @(posedge clk) begin
        if (do_access && rst && !acc_oob) begin
            for (int k = 0; k < 4; k++)
                if (acc_we[k])
                    mem[acc_idx][8*k +: 8] <= acc_din[8*k +: 8];
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    assign access_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
    assign access_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    logic        clk;
    logic        rst;

    logic [31:0] addr1, din1, dout1;
    logic        rd1, rdy1, err1;
    logic [3:0]  we1;

    logic [31:0] addr3, din3, dout3;
    logic        rd3, rdy3, err3;
    logic [3:0]  we3;

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [3:0]  we;
        logic [31:0] din;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    exp_t sbq [$];
    exp_t mon_e;

    int n_chk  = 0;
    int n_fail = 0;
    int n_rsp  = 0;
    bit mon_en = 1'b0;

    data_mem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .data_addr(addr1), .data_read(rd1),
        .data_write(we1), .data_in(din1), .data_out(dout1),
        .data_ready(rdy1), .access_err(err1)
    );

    data_mem_responder #(.DEPTH(1024), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .data_addr(addr3), .data_read(rd3),
        .data_write(we3), .data_in(din3), .data_out(dout3),
        .data_ready(rdy3), .access_err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer for the LATENCY=1 instance
    always @(negedge clk) begin
        if (mon_en && rdy1) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got data_ready=1, expected no response");
            end else begin
                mon_e = sbq.pop_front();
                chk($sformatf("sb_data[%0d]", n_rsp), dout1, mon_e.d);
                chk($sformatf("sb_err[%0d]", n_rsp), {31'd0, err1}, {31'd0, mon_e.e});
                n_rsp++;
            end
        end
    end

    // One request on the LATENCY=3 instance; request dropped after acceptance
    task automatic l3_op(input string nm, input logic [31:0] a, input logic r,
                         input logic [3:0] w, input logic [31:0] d,
                         input bit chk_d, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        addr3 = a; rd3 = r; we3 = w; din3 = d;
        @(negedge clk);
        rd3 = 1'b0; we3 = 4'd0; addr3 = 32'hFFFF_FFF0; din3 = 32'h0;
        lat = 1;
        while (!rdy3 && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd3);
        if (chk_d) chk({nm, "_data"}, dout3, exp);
        @(negedge clk);
        chk({nm, "_pulse_end"}, {31'd0, rdy3}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h10,   1'b0, 4'hF, 32'h12345678, 32'h00000000, 1'b0};
        vecs[1]  = '{32'h10,   1'b1, 4'h0, 32'h0,        32'h12345678, 1'b0};
        vecs[2]  = '{32'h12,   1'b0, 4'h5, 32'hAABBCCDD, 32'h12345678, 1'b0};
        vecs[3]  = '{32'h10,   1'b1, 4'h0, 32'h0,        32'h12BB56DD, 1'b0};
        vecs[4]  = '{32'h10,   1'b1, 4'hF, 32'hFFFFFFFF, 32'h12BB56DD, 1'b0};
        vecs[5]  = '{32'h10,   1'b1, 4'h0, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{32'h13,   1'b1, 4'h0, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{32'h20,   1'b0, 4'hF, 32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{32'h21,   1'b0, 4'h8, 32'h11223344, 32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{32'h20,   1'b1, 4'h0, 32'h0,        32'h11A5A5A5, 1'b0};
        vecs[10] = '{32'hFFC,  1'b0, 4'hF, 32'h0BADF00D, 32'h11A5A5A5, 1'b0};
        vecs[11] = '{32'hFFE,  1'b1, 4'h0, 32'h0,        32'h0BADF00D, 1'b0};
        vecs[12] = '{32'h0,    1'b0, 4'hF, 32'h00000000, 32'h0BADF00D, 1'b0};
        vecs[13] = '{32'h1000, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0BADF00D, BC};
        vecs[14] = '{32'h0,    1'b1, 4'h0, 32'h0, BC ? 32'h0 : 32'hCAFEF00D, 1'b0};
        vecs[15] = '{32'h1000, 1'b1, 4'h0, 32'h0, BC ? 32'h0 : 32'hCAFEF00D, BC};
        vecs[16] = '{32'h10,   1'b1, 4'h0, 32'h0,        32'hFFFFFFFF, 1'b0};

        rst = 1'b0;
        addr1 = 32'h0; rd1 = 1'b0; we1 = 4'd0; din1 = 32'h0;
        addr3 = 32'h0; rd3 = 1'b0; we3 = 4'd0; din3 = 32'h0;

        // Reset state
        @(negedge clk);
        chk("rst_dout1",  dout1, 32'h0);
        chk("rst_rdy1",   {31'd0, rdy1}, 32'd0);
        chk("rst_err1",   {31'd0, err1}, 32'd0);
        chk("rst_dout3",  dout3, 32'h0);
        chk("rst_rdy3",   {31'd0, rdy3}, 32'd0);
        chk("rst_err3",   {31'd0, err3}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back table on LATENCY=1 through the scoreboard
        mon_en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            addr1 = vecs[i].addr; rd1 = vecs[i].rd;
            we1 = vecs[i].we; din1 = vecs[i].din;
            sbq.push_back('{vecs[i].exp, vecs[i].err});
        end
        @(negedge clk);
        rd1 = 1'b0; we1 = 4'd0;
        @(negedge clk);
        #1;
        chk("idle_rdy1", {31'd0, rdy1}, 32'd0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        chk("sb_count", 32'(n_rsp), 32'(NV));
        mon_en = 1'b0;

        // Reset mid-traffic, memory preserved
        @(negedge clk);
        addr1 = 32'h10; rd1 = 1'b1;
        @(negedge clk);
        chk("pre_rst_rdy", {31'd0, rdy1}, 32'd1);
        chk("pre_rst_data", dout1, 32'hFFFFFFFF);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_dout", dout1, 32'h0);
        chk("mid_rst_rdy", {31'd0, rdy1}, 32'd0);
        chk("mid_rst_err", {31'd0, err1}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("held_rst_rdy", {31'd0, rdy1}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", {31'd0, rdy1}, 32'd1);
        chk("post_rst_data", dout1, 32'hFFFFFFFF);
        rd1 = 1'b0;

        // LATENCY=3: timing and BUSY-phase requests ignored
        l3_op("l3_w14", 32'h14, 1'b0, 4'hF, 32'h01010101, 1'b0, 32'h0);
        @(negedge clk);
        addr3 = 32'h10; we3 = 4'hF; din3 = 32'hDEADBEEF;
        @(negedge clk);
        chk("l3_busy_e0", {31'd0, rdy3}, 32'd0);
        addr3 = 32'h14; din3 = 32'h55555555;
        @(negedge clk);
        chk("l3_busy_e1", {31'd0, rdy3}, 32'd0);
        @(negedge clk);
        chk("l3_done_rdy", {31'd0, rdy3}, 32'd1);
        chk("l3_done_err", {31'd0, err3}, 32'd0);
        we3 = 4'd0;
        @(negedge clk);
        chk("l3_done_pulse", {31'd0, rdy3}, 32'd0);
        l3_op("l3_r10", 32'h10, 1'b1, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF);
        l3_op("l3_r14", 32'h14, 1'b1, 4'h0, 32'h0, 1'b1, 32'h01010101);

        // LATENCY=3: reset during BUSY aborts the write
        l3_op("l3_w40", 32'h40, 1'b0, 4'hF, 32'h11111111, 1'b0, 32'h0);
        @(negedge clk);
        addr3 = 32'h40; we3 = 4'hF; din3 = 32'h77777777;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        we3 = 4'd0;
        #1;
        chk("l3_rst_rdy", {31'd0, rdy3}, 32'd0);
        chk("l3_rst_dout", dout3, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        l3_op("l3_r40", 32'h40, 1'b1, 4'h0, 32'h0, 1'b1, 32'h11111111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
